// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue stage, the ALU result mux and the result stage.
package alu_issue_stage_pkg;

  typedef enum logic [3:0] {
    F_AND = 4'd0,
    F_OR  = 4'd1,
    F_XOR = 4'd2,
    F_ADD = 4'd3,
    F_SUB = 4'd4,
    F_SLT = 4'd5
  } funct_e;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [2:0] op;
    logic       binvert;
    logic       cin0;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_issue_stage_funct_decode.sv
// Combinational map from ALU function code to the per-slice controls.
module alu_funct_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [3:0] Funct,
  output logic [2:0] Op,
  output logic       BInvert,
  output logic       CIN0,
  output logic       IllegalOp
);

  always_comb begin
    Op        = OP_AND;
    BInvert   = 1'b0;
    CIN0      = 1'b0;
    IllegalOp = 1'b0;
    case (Funct)
      F_AND: Op = OP_AND;
      F_OR:  Op = OP_OR;
      F_XOR: Op = OP_XOR;
      F_ADD: Op = OP_ADD;
      F_SUB: begin
        Op      = OP_ADD;
        BInvert = 1'b1;
        CIN0    = 1'b1;
      end
      F_SLT: begin
        Op      = OP_SLT;
        BInvert = 1'b1;
        CIN0    = 1'b1;
      end
      default: IllegalOp = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry issue buffer feeding the ALU array: decodes on accept, presents the head entry.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IMM_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       Funct,
  input  logic             ImmSel,
  input  logic [WIDTH-1:0] RegA,
  input  logic [WIDTH-1:0] RegB,
  input  logic [IMM_W-1:0] Imm,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       Op,
  output logic             BInvert,
  output logic             CIN0,
  output logic             IllegalOp
);

  buf_state_e state, state_nxt;

  ctrl_t            new_ctrl;
  logic [WIDTH-1:0] new_b;
  ctrl_t            head_ctrl, tail_ctrl;
  logic [WIDTH-1:0] head_a, head_b, tail_a, tail_b;

  logic push, pop;
  logic load_head, load_tail, promote;

  alu_funct_decode u_decode (
    .Funct     (Funct),
    .Op        (new_ctrl.op),
    .BInvert   (new_ctrl.binvert),
    .CIN0      (new_ctrl.cin0),
    .IllegalOp (new_ctrl.illegal)
  );

  assign new_b = ImmSel ? {{(WIDTH-IMM_W){Imm[IMM_W-1]}}, Imm} : RegB;

  // Handshake flags come straight from the state register, so InReady has no path from OutReady.
  assign InReady  = (state != S_FULL);
  assign OutValid = (state != S_EMPTY);
  assign push     = InValid & InReady;
  assign pop      = OutValid & OutReady;

  always_ff @(posedge Clock) begin
    if (!Reset) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_tail = 1'b0;
    promote   = 1'b0;
    unique case (state)
      S_EMPTY: begin
        if (push) begin
          state_nxt = S_ONE;
          load_head = 1'b1;
        end
      end
      S_ONE: begin
        if (push && !pop) begin
          state_nxt = S_FULL;
          load_tail = 1'b1;
        end else if (!push && pop) begin
          state_nxt = S_EMPTY;
        end else if (push && pop) begin
          load_head = 1'b1;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_nxt = S_ONE;
          promote   = 1'b1;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Head is only overwritten on load, so after the last pop it keeps showing the popped entry.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      head_a    <= '0;
      head_b    <= '0;
      head_ctrl <= '0;
      tail_a    <= '0;
      tail_b    <= '0;
      tail_ctrl <= '0;
    end else begin
      if (load_head) begin
        head_a    <= RegA;
        head_b    <= new_b;
        head_ctrl <= new_ctrl;
      end else if (promote) begin
        head_a    <= tail_a;
        head_b    <= tail_b;
        head_ctrl <= tail_ctrl;
      end
      if (load_tail) begin
        tail_a    <= RegA;
        tail_b    <= new_b;
        tail_ctrl <= new_ctrl;
      end
    end
  end

  assign A         = head_a;
  assign B         = head_b;
  assign Op        = head_ctrl.op;
  assign BInvert   = head_ctrl.binvert;
  assign CIN0      = head_ctrl.cin0;
  assign IllegalOp = head_ctrl.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized scoreboard bench for alu_issue_stage against a behavioural request model.
module tb_alu_issue_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [3:0]  Funct;
  logic        ImmSel;
  logic [15:0] RegA;
  logic [15:0] RegB;
  logic [7:0]  Imm;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  Op;
  logic        BInvert;
  logic        CIN0;
  logic        IllegalOp;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        binv;
    logic        cin;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 Clock = ~Clock;

  alu_issue_stage #(.WIDTH(16), .IMM_W(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .InValid   (InValid),
    .InReady   (InReady),
    .Funct     (Funct),
    .ImmSel    (ImmSel),
    .RegA      (RegA),
    .RegB      (RegB),
    .Imm       (Imm),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .A         (A),
    .B         (B),
    .Op        (Op),
    .BInvert   (BInvert),
    .CIN0      (CIN0),
    .IllegalOp (IllegalOp)
  );

  function automatic exp_t model(logic [3:0] f, logic sel, logic [15:0] ra, logic [15:0] rb,
                                 logic [7:0] im);
    exp_t e;
    e = '0;
    e.a = ra;
    e.b = sel ? 16'($signed(im)) : rb;
    case (f)
      4'd0: e.op = 3'd0;
      4'd1: e.op = 3'd1;
      4'd2: e.op = 3'd2;
      4'd3: e.op = 3'd3;
      4'd4: begin e.op = 3'd3; e.binv = 1'b1; e.cin = 1'b1; end
      4'd5: begin e.op = 3'd4; e.binv = 1'b1; e.cin = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: compare head against the scoreboard, then record any accept at this edge.
  always @(negedge Clock) begin
    exp_t act;
    if (!Reset) begin
      q.delete();
      last = '0;
    end else begin
      act = {A, B, Op, BInvert, CIN0, IllegalOp};
      if (OutValid) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %0h, expected no valid entry", act);
        end else begin
          chk("head", 64'(act), 64'(q[0]));
          if (OutReady) begin
            last = q[0];
            void'(q.pop_front());
          end
        end
      end else begin
        chk("idle_outputs", 64'(act), 64'(last));
      end
      if (InValid && InReady) q.push_back(model(Funct, ImmSel, RegA, RegB, Imm));
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic present(input logic [3:0] f, input logic sel, input logic [15:0] ra,
                         input logic [15:0] rb, input logic [7:0] im);
    InValid = 1'b1;
    Funct   = f;
    ImmSel  = sel;
    RegA    = ra;
    RegB    = rb;
    Imm     = im;
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge Clock);
      acc = InReady;
      step();
    end
    InValid = 1'b0;
    chk("accept", 64'(acc), 64'd1);
  endtask

  task automatic send(input logic [3:0] f, input logic sel, input logic [15:0] ra,
                      input logic [15:0] rb, input logic [7:0] im);
    present(f, sel, ra, rb, im);
    wait_accept();
  endtask

  task automatic do_reset();
    Reset   = 1'b0;
    InValid = 1'b0;
    step();
    step();
    Reset = 1'b1;
  endtask

  initial begin
    Reset    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    Funct    = '0;
    ImmSel   = 1'b0;
    RegA     = '0;
    RegB     = '0;
    Imm      = '0;
    do_reset();
    chk("reset_outvalid", 64'(OutValid), 64'd0);
    chk("reset_inready", 64'(InReady), 64'd1);
    chk("reset_outputs", 64'({A, B, Op, BInvert, CIN0, IllegalOp}), 64'd0);

    // SUB appears one cycle after accept
    send(4'd4, 1'b0, 16'h0005, 16'h0003, 8'h00);
    chk("sub_outvalid", 64'(OutValid), 64'd1);
    chk("sub_ctrl", 64'({A, B, Op, BInvert, CIN0}), 64'({16'h0005, 16'h0003, 3'b011, 1'b1, 1'b1}));

    send(4'd3, 1'b1, 16'h1234, 16'hAAAA, 8'hF0);
    chk("imm_neg_b", 64'(B), 64'hFFF0);
    send(4'd3, 1'b1, 16'h1234, 16'hAAAA, 8'h7F);
    chk("imm_pos_b", 64'(B), 64'h007F);
    step();
    step();

    // Back-pressure: two accepts fill the buffer, third waits
    OutReady = 1'b0;
    send(4'd0, 1'b0, 16'h1111, 16'h0F0F, 8'h00);
    send(4'd1, 1'b0, 16'h2222, 16'hF0F0, 8'h00);
    chk("full_inready", 64'(InReady), 64'd0);
    present(4'd2, 1'b0, 16'h3333, 16'h00FF, 8'h00);
    repeat (3) step();
    chk("held_inready", 64'(InReady), 64'd0);
    chk("held_outvalid", 64'(OutValid), 64'd1);
    OutReady = 1'b1;
    wait_accept();
    repeat (4) step();

    // Push+pop every cycle in state ONE
    send(4'd5, 1'b0, 16'h0001, 16'h0002, 8'h00);
    for (int i = 0; i < 8; i++) begin
      send(4'(i % 6), 1'b0, 16'($urandom), 16'($urandom), 8'h00);
      chk("one_state", 64'({OutValid, InReady}), 64'b11);
    end
    step();
    step();

    send(4'd9, 1'b0, 16'hBEEF, 16'hCAFE, 8'h00);
    chk("illegal_ctrl", 64'({Op, BInvert, CIN0, IllegalOp}), 64'({3'b000, 1'b0, 1'b0, 1'b1}));
    step();

    for (int i = 0; i < 300; i++) begin
      InValid  = 1'($urandom);
      OutReady = ($urandom_range(0, 3) != 0);
      Funct    = 4'($urandom_range(0, 15));
      ImmSel   = 1'($urandom);
      RegA     = 16'($urandom);
      RegB     = 16'($urandom);
      Imm      = 8'($urandom);
      step();
    end
    InValid  = 1'b0;
    OutReady = 1'b1;
    repeat (4) step();

    // Reset while FULL discards both entries
    OutReady = 1'b0;
    send(4'd3, 1'b0, 16'h4444, 16'h5555, 8'h00);
    send(4'd4, 1'b1, 16'h6666, 16'h7777, 8'h80);
    chk("prereset_full", 64'(InReady), 64'd0);
    Reset = 1'b0;
    step();
    Reset    = 1'b1;
    OutReady = 1'b1;
    chk("rst_full_flags", 64'({OutValid, InReady}), 64'b01);
    chk("rst_full_outputs", 64'({A, B, Op, BInvert, CIN0, IllegalOp}), 64'd0);
    repeat (4) step();
    chk("drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue stage directly upstream of the 16-bit ALU array: accepts decoded ALU requests (function code plus operands) over a valid/ready handshake, translates the function code into the per-slice controls the ALU slices consume (`Op`, `BInvert`, carry-in of slice 0), selects register or sign-extended immediate for operand B, and buffers up to two requests. Its outputs drive the combinational ALU array, and the downstream result stage pulls them through its own ready signal.

## Interface
Parameters:
- `WIDTH`, 16: datapath width; must equal the ALU slice count.
- `IMM_W`, 8: immediate width, sign-extended to `WIDTH`.

Ports:
- `Clock`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `InValid`  in  1  upstream request valid.
- `InReady`  out  1  stage can accept a request this cycle.
- `Funct`  in  4  ALU function code.
- `ImmSel`  in  1  1: operand B = sign-extended `Imm`; 0: `RegB`.
- `RegA`  in  WIDTH  operand A.
- `RegB`  in  WIDTH  register operand B.
- `Imm`  in  IMM_W  immediate.
- `OutValid`  out  1  head entry valid toward ALU.
- `OutReady`  in  1  downstream consumes head entry.
- `A`  out  WIDTH  operand A to slice inputs.
- `B`  out  WIDTH  selected operand B.
- `Op`  out  3  result-mux select, shared by all slices.
- `BInvert`  out  1  B inversion, shared by all slices.
- `CIN0`  out  1  carry into slice 0.
- `IllegalOp`  out  1  head entry carried an undefined `Funct`.

## Operation
- Decode on accept, stored decoded in the entry:
  - 0 AND: Op=000, BInvert=0, CIN0=0.
  - 1 OR: Op=001, BInvert=0, CIN0=0.
  - 2 XOR: Op=010, BInvert=0, CIN0=0.
  - 3 ADD: Op=011, BInvert=0, CIN0=0.
  - 4 SUB: Op=011, BInvert=1, CIN0=1.
  - 5 SLT: Op=100, BInvert=1, CIN0=1.
  - 6–15: Op=000, BInvert=0, CIN0=0, IllegalOp=1. The entry is still accepted and issued, never dropped.
- B = `ImmSel` ? {{(WIDTH-IMM_W){Imm[IMM_W-1]}}, Imm} : `RegB`, resolved at accept time.
- Two-entry buffer, states EMPTY / ONE / FULL. Push = `InValid & InReady`; pop = `OutValid & OutReady`.
  - EMPTY: push→ONE.
  - ONE: push only→FULL; pop only→EMPTY; push+pop→ONE, with the new entry becoming head.
  - FULL: pop→ONE, second entry promoted to head. No push is possible because `InReady`=0.
- Requests issue strictly in acceptance order.
- `A`/`B`/`Op`/`BInvert`/`CIN0`/`IllegalOp` always reflect the head entry and hold stable while `OutValid`=1 and `OutReady`=0.

## Timing
- `InReady` = (state != FULL), driven from a register with no combinational path from `OutReady`.
- Latency: request accepted in cycle N appears on outputs with `OutValid`=1 in cycle N+1 when the buffer was empty.
- Sustained throughput is 1 request per cycle while `OutReady`=1.
- Reset (`Reset`=0 at a clock edge): state EMPTY, `OutValid`=0, `InReady`=1 from the next cycle; `A`, `B`=0, `Op`=000, `BInvert`=0, `CIN0`=0, `IllegalOp`=0. Buffered entries are discarded, including mid-transfer ones.
- Output values when `OutValid`=0 are don't-care to the consumer but must equal the reset values or the last popped entry; no X propagation.

## Structure
- Shared package: the `Funct` codes (`F_AND`..`F_SLT`), the `Op` encodings (`OP_AND`=000, `OP_OR`=001, `OP_XOR`=010, `OP_ADD`=011, `OP_SLT`=100), and the state encoding. These are shared with the ALU result mux and the result stage.
- One sub-module: `alu_funct_decode`, a combinational map from `Funct` to {Op, BInvert, CIN0, IllegalOp}. The buffer and state machine stay in the top module.

## Test plan
- Reset then SUB, `RegA`=0x0005, `RegB`=0x0003, `OutReady`=1 -> next cycle `OutValid`=1, A=0x0005, B=0x0003, Op=011, BInvert=1, CIN0=1.
- ADD, `ImmSel`=1, `Imm`=0xF0 -> B=0xFFF0. Then `Imm`=0x7F -> B=0x007F.
- Hold `OutReady`=0 and push 3 requests -> `InReady`=0 after 2 accepts and the third is held. Then raise `OutReady` -> outputs issue in order with no loss or duplication.
- In state ONE, push+pop in the same cycle for 8 cycles (`Funct` 0..5 cycling) -> state remains ONE, one output per cycle, decode matches the table.
- `Funct`=9 -> issued with IllegalOp=1, Op=000, BInvert=0, CIN0=0.
- Reset asserted while FULL -> next cycle `OutValid`=0, `InReady`=1, all outputs at reset values.
